// File: rtl/l2_pkg.sv
// Shared L2 definitions for the Ethernet header parser and the EtherType classifier.
package l2_pkg;

  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [15:0] ETH_IPV6  = 16'h86DD;
  localparam logic [15:0] TPID_CTAG = 16'h8100;
  localparam logic [15:0] TPID_STAG = 16'h88A8;
  localparam int          MAC_W     = 48;
  localparam int          ETYPE_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_TCI,
    ST_PAYLOAD
  } parser_state_e;

endpackage

// File: rtl/eth_header_parser.sv
// Byte-serial Ethernet L2 header parser: extracts MACs, strips up to MAX_TAGS
// VLAN tags and reports the effective EtherType with a one-cycle strobe.
module eth_header_parser #(
  parameter logic [15:0] TPID_CTAG = l2_pkg::TPID_CTAG,
  parameter logic [15:0] TPID_STAG = l2_pkg::TPID_STAG,
  parameter int unsigned MAX_TAGS  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_sop,
  input  logic                        rx_eop,
  output logic [l2_pkg::MAC_W-1:0]    dst_mac,
  output logic [l2_pkg::MAC_W-1:0]    src_mac,
  output logic [l2_pkg::ETYPE_W-1:0]  eth_type,
  output logic [11:0]                 vlan_id,
  output logic [1:0]                  vlan_cnt,
  output logic                        hdr_valid,
  output logic                        hdr_err,
  output logic                        busy
);
  import l2_pkg::*;

  localparam logic [1:0] LP_MAX_TAGS = 2'(MAX_TAGS);

  parser_state_e r_state, w_next_state;
  logic [3:0]    r_byte_cnt;
  logic [1:0]    r_tag_cnt;
  logic [47:0]   r_dst_sh, r_src_sh;
  logic [7:0]    r_type_hi;
  logic [3:0]    r_vid_hi;
  logic [11:0]   r_vid_sh;
  logic [47:0]   r_dst_mac, r_src_mac;
  logic [15:0]   r_eth_type;
  logic [11:0]   r_vlan_id;
  logic [1:0]    r_vlan_cnt;
  logic          r_hdr_valid, r_hdr_err;

  logic [15:0]   w_type;
  logic          w_strip, w_hdr_done, w_hdr_abort;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_hdr_done   = 1'b0;
    w_hdr_abort  = 1'b0;
    w_type       = {r_type_hi, rx_data};
    w_strip      = ((w_type == TPID_CTAG) || (w_type == TPID_STAG)) && (r_tag_cnt < LP_MAX_TAGS);
    if (rx_valid) begin
      if (rx_sop) begin
        // A sop restarts the frame; only an unfinished header counts as an abort.
        w_hdr_abort  = rx_eop || ((r_state != ST_IDLE) && (r_state != ST_PAYLOAD));
        w_next_state = rx_eop ? ST_IDLE : ST_DST;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_DST: begin
            if (rx_eop) begin
              w_hdr_abort  = 1'b1;
              w_next_state = ST_IDLE;
            end else if (r_byte_cnt == 4'd5) begin
              w_next_state = ST_SRC;
            end
          end
          ST_SRC: begin
            if (rx_eop) begin
              w_hdr_abort  = 1'b1;
              w_next_state = ST_IDLE;
            end else if (r_byte_cnt == 4'd5) begin
              w_next_state = ST_TYPE;
            end
          end
          ST_TYPE: begin
            if (r_byte_cnt == 4'd1 && !w_strip) begin
              w_hdr_done   = 1'b1;
              w_next_state = rx_eop ? ST_IDLE : ST_PAYLOAD;
            end else if (rx_eop) begin
              w_hdr_abort  = 1'b1;
              w_next_state = ST_IDLE;
            end else if (r_byte_cnt == 4'd1) begin
              w_next_state = ST_TCI;
            end
          end
          ST_TCI: begin
            if (rx_eop) begin
              w_hdr_abort  = 1'b1;
              w_next_state = ST_IDLE;
            end else if (r_byte_cnt == 4'd1) begin
              w_next_state = ST_TYPE;
            end
          end
          ST_PAYLOAD: if (rx_eop) w_next_state = ST_IDLE;
          default:    w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
    end else if (rx_valid) begin
      r_state <= w_next_state;
      if (rx_sop)                       r_byte_cnt <= 4'd1;
      else if (w_next_state != r_state) r_byte_cnt <= '0;
      else if (r_state != ST_IDLE)      r_byte_cnt <= r_byte_cnt + 4'd1;
    end
  end

  // NOTE: shadow registers are reset too, so a header never exposes bytes of an older frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dst_sh    <= '0;
      r_src_sh    <= '0;
      r_type_hi   <= '0;
      r_vid_hi    <= '0;
      r_vid_sh    <= '0;
      r_tag_cnt   <= '0;
      r_dst_mac   <= '0;
      r_src_mac   <= '0;
      r_eth_type  <= '0;
      r_vlan_id   <= '0;
      r_vlan_cnt  <= '0;
      r_hdr_valid <= 1'b0;
      r_hdr_err   <= 1'b0;
    end else begin
      r_hdr_valid <= w_hdr_done;
      r_hdr_err   <= w_hdr_abort;
      if (rx_valid && rx_sop) begin
        r_dst_sh  <= {40'd0, rx_data};
        r_src_sh  <= '0;
        r_type_hi <= '0;
        r_vid_hi  <= '0;
        r_vid_sh  <= '0;
        r_tag_cnt <= '0;
      end else if (rx_valid) begin
        case (r_state)
          ST_DST:  r_dst_sh <= {r_dst_sh[39:0], rx_data};
          ST_SRC:  r_src_sh <= {r_src_sh[39:0], rx_data};
          ST_TYPE: if (r_byte_cnt == 4'd0) r_type_hi <= rx_data;
          ST_TCI: begin
            if (r_byte_cnt == 4'd0) begin
              r_vid_hi <= rx_data[3:0];
            end else begin
              // Only the outermost tag supplies the reported VID.
              if (r_tag_cnt == 2'd0) r_vid_sh <= {r_vid_hi, rx_data};
              r_tag_cnt <= r_tag_cnt + 2'd1;
            end
          end
          default: ;
        endcase
      end
      if (w_hdr_done) begin
        r_dst_mac  <= r_dst_sh;
        r_src_mac  <= r_src_sh;
        r_eth_type <= w_type;
        r_vlan_id  <= r_vid_sh;
        r_vlan_cnt <= r_tag_cnt;
      end
    end
  end

  assign dst_mac   = r_dst_mac;
  assign src_mac   = r_src_mac;
  assign eth_type  = r_eth_type;
  assign vlan_id   = r_vlan_id;
  assign vlan_cnt  = r_vlan_cnt;
  assign hdr_valid = r_hdr_valid;
  assign hdr_err   = r_hdr_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_eth_header_parser.sv
// Randomized scoreboard bench for eth_header_parser against a frame-level reference model.
module tb_eth_header_parser;

  localparam int MAX_TAGS = 2;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];
  typedef struct {
    bit          is_err;
    int          cyc;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    logic [11:0] vid;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sop, rx_eop;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] eth_type;
  logic [11:0] vlan_id;
  logic [1:0]  vlan_cnt;
  logic        hdr_valid, hdr_err, busy;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  exp_t    sb[$];
  exp_t    m_last;
  exp_t    mon_e;
  bit      m_in_frame;
  bit      m_reported;
  byte_q_t m_buf;
  byte_q_t fr, fr2;
  word_q_t w;
  int      nt, plen, mode;

  eth_header_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .dst_mac(dst_mac), .src_mac(src_mac),
    .eth_type(eth_type), .vlan_id(vlan_id), .vlan_cnt(vlan_cnt),
    .hdr_valid(hdr_valid), .hdr_err(hdr_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Header is complete when the buffer ends exactly on the first non-stripped type word.
  function automatic bit hdr_complete(input byte_q_t b, output logic [15:0] et, output int tags);
    int pos;
    logic [15:0] t;
    pos = 12; tags = 0; et = '0;
    while (1'b1) begin
      if (b.size() < pos + 2) return 1'b0;
      t = {b[pos], b[pos+1]};
      if ((t == 16'h8100 || t == 16'h88A8) && tags < MAX_TAGS) begin
        pos += 4;
        tags++;
      end else begin
        et = t;
        return (b.size() == pos + 2);
      end
    end
    return 1'b0;
  endfunction

  task automatic push_err();
    exp_t e;
    e = m_last; e.is_err = 1'b1; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] d, input bit sop, input bit eop);
    logic [15:0] et;
    logic [7:0]  b14;
    int          tags;
    exp_t        e;
    if (sop) begin
      if (eop || (m_in_frame && !m_reported)) push_err();
      m_buf = {d};
      m_in_frame = !eop;
      m_reported = 1'b0;
    end else if (m_in_frame) begin
      if (m_reported) begin
        if (eop) m_in_frame = 1'b0;
      end else begin
        m_buf.push_back(d);
        if (hdr_complete(m_buf, et, tags)) begin
          e.is_err = 1'b0; e.cyc = cyc; e.dst = '0; e.src = '0;
          for (int i = 0; i < 6; i++) begin
            e.dst = {e.dst[39:0], m_buf[i]};
            e.src = {e.src[39:0], m_buf[i+6]};
          end
          e.et  = et;
          e.cnt = 2'(tags);
          b14   = (tags > 0) ? m_buf[14] : 8'h00;
          e.vid = (tags > 0) ? {b14[3:0], m_buf[15]} : 12'h000;
          m_last = e;
          sb.push_back(e);
          m_reported = 1'b1;
          if (eop) m_in_frame = 1'b0;
        end else if (eop) begin
          push_err();
          m_in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rx_valid = 1'b0;
      rx_sop   = 1'($urandom_range(1));
      rx_eop   = 1'($urandom_range(1));
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit sop, input bit eop);
    rx_data = d; rx_valid = 1'b1; rx_sop = sop; rx_eop = eop;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    model_byte(d, sop, eop);
    check("busy", busy, m_in_frame);
  endtask

  // gap < 0: rx_valid low between every byte; gap > 0: percent chance of idle cycles.
  task automatic send(input byte_q_t f, input int n, input bit with_eop, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap < 0 && i > 0) idle(1);
      else if (gap > 0) while (int'($urandom_range(99)) < gap) idle(1);
      drive_byte(f[i], i == 0, with_eop && (i == n - 1));
    end
  endtask

  function automatic byte_q_t build_frame(input logic [47:0] d, input logic [47:0] s,
                                          input word_q_t words, input int pl);
    byte_q_t q;
    for (int i = 5; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(s[i*8 +: 8]);
    foreach (words[i]) begin
      q.push_back(words[i][15:8]);
      q.push_back(words[i][7:0]);
    end
    for (int i = 0; i < pl; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  always @(negedge clk) begin
    if (hdr_valid || hdr_err) begin
      check("strobe_exclusive", {63'd0, hdr_valid & hdr_err}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {62'd0, hdr_valid, hdr_err}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hdr_err",      hdr_err,   mon_e.is_err);
        check("hdr_valid",    hdr_valid, !mon_e.is_err);
        check("strobe_cycle", cyc,       mon_e.cyc);
        check("dst_mac",      dst_mac,   mon_e.dst);
        check("src_mac",      src_mac,   mon_e.src);
        check("eth_type",     eth_type,  mon_e.et);
        check("vlan_id",      vlan_id,   mon_e.vid);
        check("vlan_cnt",     vlan_cnt,  mon_e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = '0;
    m_last = '{default: '0};
    m_in_frame = 1'b0; m_reported = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dst_mac", dst_mac, 0);
    check("rst_eth_type", eth_type, 0);
    check("rst_strobes", {hdr_valid, hdr_err, busy}, 0);
    rst = 1'b0;
    idle(2);

    // Untagged IPv4
    w = {16'h0800};
    fr = build_frame(48'h010203040506, 48'h0A0B0C0D0E0F, w, 46);
    send(fr, fr.size(), 1'b1, 0);
    idle(2);
    check("ipv4_eth_type", eth_type, 16'h0800);
    check("ipv4_vlan", {vlan_cnt, vlan_id}, 0);
    check("ipv4_dst", dst_mac, 48'h010203040506);
    check("ipv4_src", src_mac, 48'h0A0B0C0D0E0F);

    // Single C-tag
    w = {16'h8100, 16'h2064, 16'h86DD};
    fr = build_frame(48'h111111111111, 48'h222222222222, w, 46);
    send(fr, fr.size(), 1'b1, 0);
    idle(2);
    check("ctag_eth_type", eth_type, 16'h86DD);
    check("ctag_vlan_id", vlan_id, 12'h064);
    check("ctag_vlan_cnt", vlan_cnt, 2'd1);

    // QinQ plus a third TPID left unstripped
    w = {16'h88A8, 16'h1ABC, 16'h8100, 16'h0123, 16'h8100};
    fr = build_frame(48'h333333333333, 48'h444444444444, w, 46);
    send(fr, fr.size(), 1'b1, 0);
    idle(2);
    check("qinq_eth_type", eth_type, 16'h8100);
    check("qinq_vlan_cnt", vlan_cnt, 2'd2);
    check("qinq_vlan_id", vlan_id, 12'hABC);

    // Runt: eop on byte 9
    w = {16'h0800};
    fr = build_frame(48'h555555555555, 48'h666666666666, w, 10);
    send(fr, 10, 1'b1, 0);
    idle(2);
    check("runt_keeps_type", eth_type, 16'h8100);
    check("runt_keeps_dst", dst_mac, 48'h333333333333);

    // rx_valid toggled every other cycle
    w = {16'h0800};
    fr = build_frame(48'h777777777777, 48'h888888888888, w, 20);
    send(fr, fr.size(), 1'b1, -1);
    idle(2);
    check("toggle_eth_type", eth_type, 16'h0800);
    check("toggle_dst", dst_mac, 48'h777777777777);

    // sop at byte 5, then a full IPv6 frame
    w = {16'h0800};
    fr = build_frame(48'h999999999999, 48'hAAAAAAAAAAAA, w, 10);
    send(fr, 5, 1'b0, 0);
    w = {16'h86DD};
    fr = build_frame(48'hBBBBBBBBBBBB, 48'hCCCCCCCCCCCC, w, 10);
    send(fr, fr.size(), 1'b1, 0);
    idle(2);
    check("abort_eth_type", eth_type, 16'h86DD);

    // rst while byte 8 is presented, remainder ignored
    w = {16'h0800};
    fr = build_frame(48'hDDDDDDDDDDDD, 48'hEEEEEEEEEEEE, w, 12);
    send(fr, 8, 1'b0, 0);
    rst = 1'b1; rx_valid = 1'b1; rx_data = fr[8];
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    m_in_frame = 1'b0; m_reported = 1'b0;
    m_last = '{default: '0};
    check("rstmid_outputs", {dst_mac, eth_type}, 0);
    check("rstmid_vlan_busy", {vlan_id, vlan_cnt, hdr_valid, hdr_err, busy}, 0);
    for (int i = 9; i < fr.size(); i++) drive_byte(fr[i], 1'b0, i == fr.size() - 1);
    idle(2);
    check("rstmid_no_update", eth_type, 16'h0000);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      w = {};
      nt = $urandom_range(0, 3);
      repeat (nt) begin
        w.push_back($urandom_range(1) ? 16'h8100 : 16'h88A8);
        w.push_back(16'($urandom));
      end
      case ($urandom_range(4))
        0:       w.push_back(16'h0800);
        1:       w.push_back(16'h86DD);
        2:       w.push_back(16'h8100);
        3:       w.push_back(16'h88A8);
        default: w.push_back(16'($urandom));
      endcase
      plen = $urandom_range(0, 12);
      fr = build_frame({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, w, plen);
      mode = $urandom_range(9);
      if (mode == 0) begin
        send(fr, $urandom_range(1, fr.size()), 1'b1, 20);
      end else if (mode == 1) begin
        send(fr, $urandom_range(1, fr.size() - 1), 1'b0, 20);
      end else if (mode == 2) begin
        repeat (3) drive_byte(8'($urandom), 1'b0, 1'($urandom_range(1)));
        send(fr, fr.size(), 1'b1, 20);
      end else begin
        send(fr, fr.size(), 1'b1, 20);
      end
      idle($urandom_range(0, 2));
    end

    w = {16'h0800};
    fr2 = build_frame(48'h0102030405AA, 48'h0A0B0C0D0EBB, w, 4);
    send(fr2, fr2.size(), 1'b1, 0);
    idle(3);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
